// File: rtl/string_length_stream_pkg.sv
// string_length_stream_pkg: state encodings and default widths for the string length streamer.
package string_length_stream_pkg;
   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      REPORT = 2'd2
   } state_t;
   localparam int DEF_LANES  = 8;
   localparam int DEF_CHAR_W = 8;
   localparam int DEF_LEN_W  = 16;
endpackage

// File: rtl/first_null_lane.sv
// first_null_lane: finds the lowest-index all-zero character lane of a beat.
module first_null_lane
   import string_length_stream_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int CHAR_W = DEF_CHAR_W,
   localparam int IW    = LANES > 1 ? $clog2(LANES) : 1
) (
   input  logic [LANES*CHAR_W-1:0] data,
   output logic                    any_null,
   output logic [IW-1:0]           idx
);
   logic [LANES-1:0] nulls;
   always_comb begin
      for (int i = 0; i < LANES; i++) nulls[i] = ~|data[i*CHAR_W +: CHAR_W];
   end
   // Scanning downward lets the lowest null lane win.
   always_comb begin
      any_null = |nulls;
      idx = '0;
      for (int i = LANES - 1; i >= 0; i--) if (nulls[i]) idx = IW'(i);
   end
endmodule

// File: rtl/string_length_stream.sv
// string_length_stream: measures null-terminated strings arriving as multi-lane beats.
module string_length_stream
   import string_length_stream_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int CHAR_W = DEF_CHAR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*CHAR_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LEN_W-1:0]        out_length,
   output logic                    out_terminated,
   output logic                    out_saturated
);
   localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
   state_t state, next;
   logic any_null, accept;
   logic [IW-1:0] idx;
   logic [LEN_W:0] sum;
   first_null_lane #(.LANES(LANES), .CHAR_W(CHAR_W)) u_first_null (
      .data(in_data),
      .any_null(any_null),
      .idx(idx)
   );
   assign in_ready = state != REPORT;
   assign out_valid = state == REPORT;
   assign accept = in_valid && in_ready;
   // out_length doubles as the running count while accumulating.
   assign sum = {1'b0, out_length} + (any_null ? (LEN_W+1)'(idx) : (LEN_W+1)'(LANES));
   always_comb begin
      next = state;
      if (state == ACCUM && accept) next = in_last ? REPORT : any_null ? DRAIN : ACCUM;
      else if (state == DRAIN && accept && in_last) next = REPORT;
      else if (state == REPORT && out_ready) next = ACCUM;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ACCUM;
         out_length <= '0;
         out_terminated <= 1'b0;
         out_saturated <= 1'b0;
      end else begin
         state <= next;
         if (state == ACCUM && accept) begin
            out_length <= sum[LEN_W] ? '1 : sum[LEN_W-1:0];
            out_terminated <= any_null;
            out_saturated <= out_saturated | sum[LEN_W];
         end else if (state == REPORT && out_ready) begin
            out_length <= '0;
            out_terminated <= 1'b0;
            out_saturated <= 1'b0;
         end
      end
   end
endmodule
